f1_light_seq: RTL and testbench

- Light-sequence controller directly downstream of the 4-bit shift-register/LFSR stage; consumes its pseudo-random value as a hold delay.
- On a start trigger, fills an 8-light bar one light per tick.
- Holds all lights on for a random number of ticks, then extinguishes them all and pulses done (the reaction-time start point).
- Tick strobe comes from the shared clock-tick divider.

---
 rtl/f1_light_seq_pkg.sv | 15 +
 rtl/f1_light_seq_hold_down_counter.sv | 29 ++
 rtl/f1_light_seq.sv | 104 ++++++++++
 tb/tb_f1_light_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/f1_light_seq_pkg.sv
// Shared types and default sizing for the F1 start-light sequencer.
// The sequencer fills the light bar, holds it for a random delay, then goes dark.
package f1_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int N_LIGHTS_DEF  = 8;
   localparam int RND_WIDTH_DEF = 4;
   localparam int MIN_DELAY_DEF = 1;

endpackage

// File: rtl/f1_light_seq_hold_down_counter.sv
// Loadable down-counter for the all-lights-on hold period.
// 'one' flags the last hold tick; the FSM never decrements past it.
module hold_down_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic             one
);

   logic [WIDTH-1:0] count;

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec) begin
         count <= count - 1'b1;
      end
   end

   assign one = (count == WIDTH'(1));

endmodule

// File: rtl/f1_light_seq.sv
// F1 start-light controller: fills the bar one light per tick, holds for a
// random number of ticks, then extinguishes everything and pulses done.
import f1_pkg::*;

module f1_light_seq #(
   parameter int N_LIGHTS  = N_LIGHTS_DEF,
   parameter int RND_WIDTH = RND_WIDTH_DEF,
   parameter int MIN_DELAY = MIN_DELAY_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 trigger,
   input  logic [RND_WIDTH-1:0] rnd_in,
   output logic [N_LIGHTS-1:0]  data_out,
   output logic                 busy,
   output logic                 done
);

   state_t                state, state_next;
   logic [N_LIGHTS-1:0]   data_next;
   logic                  done_next;
   logic                  busy_next;
   logic                  cnt_load;
   logic                  cnt_dec;
   logic                  cnt_one;
   logic [RND_WIDTH-1:0]  hold_value;

   // A zero draw would mean no hold at all, so it is replaced by the minimum delay.
   assign hold_value = (rnd_in == '0) ? RND_WIDTH'(MIN_DELAY) : rnd_in;

   hold_down_counter #(
      .WIDTH (RND_WIDTH)
   ) u_hold_cnt (
      .clk        (clk),
      .rst        (rst),
      .load       (cnt_load),
      .load_value (hold_value),
      .dec        (cnt_dec),
      .one        (cnt_one)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         data_out <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_next;
         data_out <= data_next;
         busy     <= busy_next;
         done     <= done_next;
      end
   end

   // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
   always_comb begin
      state_next = state;
      data_next  = data_out;
      done_next  = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;

      unique case (state)
         IDLE: begin
            // The first light comes on straight from the trigger, not from a tick.
            data_next = '0;
            if (trigger) begin
               state_next = FILL;
               data_next  = N_LIGHTS'(1);
            end
         end
         FILL: begin
            if (en) begin
               if (data_out != '1) begin
                  data_next = {data_out[N_LIGHTS-2:0], 1'b1};
               end else begin
                  cnt_load   = 1'b1;
                  state_next = HOLD;
               end
            end
         end
         HOLD: begin
            if (en) begin
               if (cnt_one) begin
                  data_next  = '0;
                  done_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            data_next  = '0;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

endmodule

// File: tb/tb_f1_light_seq.sv
// Directed self-checking bench for f1_light_seq: reset, fill/hold timing,
// zero-delay substitution, busy trigger, mid-run reset and auto-repeat.
module tb_f1_light_seq;

   logic       clk;
   logic       rst;
   logic       en;
   logic       trigger;
   logic [3:0] rnd_in;
   logic [7:0] data_out;
   logic       busy;
   logic       done;

   int tests_run    = 0;
   int tests_failed = 0;

   f1_light_seq dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .trigger  (trigger),
      .rnd_in   (rnd_in),
      .data_out (data_out),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One tick: gap-1 idle cycles, then a cycle with en=1.
   task automatic tick(input int gap);
      en = 1'b0;
      repeat (gap - 1) step();
      en = 1'b1;
      step();
      en = 1'b0;
   endtask

   // Trigger a run and tick through the 8-tick fill; leaves the DUT in HOLD.
   task automatic fill_run(input string tag, input int gap);
      logic [8:0] full;
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      tests_run++;
      if (data_out !== 8'h01 || busy !== 1'b1 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s start: data_out=%h busy=%b done=%b, expected 01/1/0", tag, data_out, busy, done);
      end
      for (int t = 1; t <= 8; t++) begin
         tick(gap);
         full = (t < 8) ? ((9'd1 << (t + 1)) - 9'd1) : 9'h0FF;
         tests_run++;
         if (data_out !== full[7:0] || busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s fill tick %0d: data_out=%h busy=%b done=%b, expected %h/1/0",
                     tag, t, data_out, busy, done, full[7:0]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; trigger = 1'b0; en = 1'b0; rnd_in = 4'd0;
      for (int i = 0; i < 2; i++) begin
         en = ~en;
         step();
         tests_run++;
         if (data_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset cycle %0d: data_out=%h busy=%b done=%b, expected 00/0/0", i, data_out, busy, done);
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         en = (i % 2 == 0);
         step();
         tests_run++;
         if (data_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle cycle %0d: data_out=%h busy=%b done=%b, expected 00/0/0", i, data_out, busy, done);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_basic_run();
      rnd_in = 4'd3;
      fill_run("basic", 4);
      // Lights hold with en low.
      repeat (3) step();
      tests_run++;
      if (data_out !== 8'hFF || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic no-en hold: data_out=%h busy=%b, expected ff/1", data_out, busy);
      end
      for (int t = 9; t <= 10; t++) begin
         tick(4);
         tests_run++;
         if (data_out !== 8'hFF || busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic hold tick %0d: data_out=%h busy=%b done=%b, expected ff/1/0", t, data_out, busy, done);
         end
      end
      tick(4);
      tests_run++;
      if (data_out !== 8'h00 || busy !== 1'b0 || done !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic lights-out tick 11: data_out=%h busy=%b done=%b, expected 00/0/1", data_out, busy, done);
      end
      step();
      tests_run++;
      if (data_out !== 8'h00 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic done width: data_out=%h done=%b, expected 00/0", data_out, done);
      end
   endtask

   task automatic test_zero_rnd();
      rnd_in = 4'd0;
      fill_run("zero_rnd", 2);
      tick(2);
      tests_run++;
      if (data_out !== 8'h00 || busy !== 1'b0 || done !== 1'b1) begin
         tests_failed++;
         $display("FAIL zero_rnd tick 9: data_out=%h busy=%b done=%b, expected 00/0/1", data_out, busy, done);
      end
      step();
      tests_run++;
      if (done !== 1'b0) begin
         tests_failed++;
         $display("FAIL zero_rnd done width: done=%b, expected 0", done);
      end
   endtask

   task automatic test_busy_trigger();
      rnd_in = 4'd5;
      fill_run("busy_trig", 3);
      rnd_in  = 4'd2;
      trigger = 1'b1;
      for (int h = 1; h <= 4; h++) begin
         tick(3);
         tests_run++;
         if (data_out !== 8'hFF || busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_trig hold tick %0d: data_out=%h busy=%b done=%b, expected ff/1/0", h, data_out, busy, done);
         end
      end
      trigger = 1'b0;
      tick(3);
      tests_run++;
      if (data_out !== 8'h00 || busy !== 1'b0 || done !== 1'b1) begin
         tests_failed++;
         $display("FAIL busy_trig lights-out: data_out=%h busy=%b done=%b, expected 00/0/1", data_out, busy, done);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         tests_run++;
         if (data_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_trig no rerun %0d: data_out=%h busy=%b done=%b, expected 00/0/0", i, data_out, busy, done);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      rnd_in = 4'd4;
      fill_run("mid_rst", 2);
      tick(2);
      tests_run++;
      if (data_out !== 8'hFF || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_rst pre-reset: data_out=%h busy=%b, expected ff/1", data_out, busy);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests_run++;
      if (data_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_rst after reset: data_out=%h busy=%b done=%b, expected 00/0/0", data_out, busy, done);
      end
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         tests_run++;
         if (data_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_rst idle %0d: data_out=%h busy=%b done=%b, expected 00/0/0", i, data_out, busy, done);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [8:0] exp_data;
      logic       exp_done;
      int         m;
      rnd_in  = 4'd1;
      en      = 1'b1;
      trigger = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         m = ((k - 1) % 10) + 1;
         exp_done = (m == 10);
         if (m <= 8)      exp_data = (9'd1 << m) - 9'd1;
         else if (m == 9) exp_data = 9'h0FF;
         else             exp_data = 9'h000;
         tests_run++;
         if (data_out !== exp_data[7:0] || done !== exp_done || busy !== !exp_done) begin
            tests_failed++;
            $display("FAIL b2b cycle %0d: data_out=%h busy=%b done=%b, expected %h/%b/%b",
                     k, data_out, busy, done, exp_data[7:0], !exp_done, exp_done);
         end
      end
      trigger = 1'b0;
      en      = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; trigger = 1'b0; rnd_in = 4'd0;
      test_reset();
      test_basic_run();
      test_zero_rnd();
      test_busy_trigger();
      test_reset_mid_run();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
